// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: OV7670 parallel-bus capture into RGB565 pixel strobes with linear frame-buffer addresses.
// Optional feature: define OV7670_CAPTURE_DOWNSCALE_EN for 2:1 decimation in both axes.
module ov7670_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              config_done,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              overflow
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0] H_L = CW'(H_ACTIVE);
    localparam logic [LW-1:0] V_L = LW'(V_ACTIVE);
`ifdef OV7670_CAPTURE_DOWNSCALE_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [ADDR_W:0] STEP_FULL = (ADDR_W + 1)'(H_ACTIVE);
    localparam logic [ADDR_W:0] STEP_HALF = (ADDR_W + 1)'(H_ACTIVE / 2);

    typedef enum logic [1:0] {WAIT_CFG, WAIT_VS, ACTIVE} state_t;
    state_t state, state_nx;

    logic [2:0]        pclk_s, vs_s, href_s;
    logic [7:0]        d_s0, d_s1, e_data, hi;
    logic              e_rise, e_href, e_href_rise, e_href_fall, e_vs_rise, e_vs_fall;
    logic              phase, ph, byte_ev, pix_ev, in_rng, keep;
    logic [CW-1:0]     col;
    logic [LW-1:0]     line;
    logic [ADDR_W:0]   base, sum, line_step;
    logic              c_v, c_fs, c_fd;
    logic [15:0]       c_data;
    logic [ADDR_W-1:0] c_addr;
    logic              fs_c, fd_c, act;

    // two-flop synchronisers; the third flop on control lines provides edge detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pclk_s <= '0;
            vs_s   <= '0;
            href_s <= '0;
            d_s0   <= '0;
            d_s1   <= '0;
        end else begin
            pclk_s <= {pclk_s[1:0], cam_pclk};
            vs_s   <= {vs_s[1:0], cam_vsync};
            href_s <= {href_s[1:0], cam_href};
            d_s0   <= cam_data;
            d_s1   <= d_s0;
        end

    // register decoded bus events alongside the synchronised data byte
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_rise      <= 1'b0;
            e_href      <= 1'b0;
            e_href_rise <= 1'b0;
            e_href_fall <= 1'b0;
            e_vs_rise   <= 1'b0;
            e_vs_fall   <= 1'b0;
            e_data      <= '0;
        end else begin
            e_rise      <= pclk_s[1] & ~pclk_s[2];
            e_href      <= href_s[1];
            e_href_rise <= href_s[1] & ~href_s[2];
            e_href_fall <= ~href_s[1] & href_s[2];
            e_vs_rise   <= vs_s[1] & ~vs_s[2];
            e_vs_fall   <= ~vs_s[1] & vs_s[2];
            e_data      <= d_s1;
        end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT_CFG;
        else state <= state_nx;

    // FSM next state: losing config_done always returns to WAIT_CFG
    always_comb
        state_nx = !config_done                    ? WAIT_CFG :
                   state == WAIT_CFG               ? WAIT_VS  :
                   (state == WAIT_VS && e_vs_fall) ? ACTIVE   :
                   (state == ACTIVE && e_vs_rise)  ? WAIT_VS  : state;

    // FSM outputs: frame pulses and capture enable
    always_comb begin
        fs_c = state == WAIT_VS && config_done && e_vs_fall;
        fd_c = state == ACTIVE && config_done && e_vs_rise;
        act  = state == ACTIVE && config_done;
    end

    // byte pairing, range limits and incremental address arithmetic
    always_comb begin
        ph        = e_href_rise ? 1'b0 : phase;
        byte_ev   = e_rise & e_href;
        pix_ev    = byte_ev & ph;
        in_rng    = col < H_L && line < V_L;
        keep      = !DS || (!col[0] && !line[0]);
        sum       = base + (ADDR_W + 1)'(col >> DS);
        line_step = DS ? (line[0] ? STEP_HALF : '0) : STEP_FULL;
    end

    // byte phase, position counters and the pixel candidate stage
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase    <= 1'b0;
            hi       <= '0;
            col      <= '0;
            line     <= '0;
            base     <= '0;
            overflow <= 1'b0;
            c_v      <= 1'b0;
            c_fs     <= 1'b0;
            c_fd     <= 1'b0;
            c_data   <= '0;
            c_addr   <= '0;
        end else begin
            c_v  <= 1'b0;
            c_fs <= fs_c;
            c_fd <= fd_c;
            if (byte_ev) begin
                phase <= ~ph;
                if (!ph) hi <= e_data;
            end else if (e_href_rise || e_href_fall) begin
                phase <= 1'b0;
            end
            if (fs_c) begin
                col      <= '0;
                line     <= '0;
                base     <= '0;
                overflow <= 1'b0;
            end else if (act) begin
                if (pix_ev) begin
                    if (in_rng) begin
                        col    <= col + 1'b1;
                        c_v    <= keep;
                        c_data <= {hi, e_data};
                        c_addr <= sum[ADDR_W-1:0];
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (e_href_fall && col != '0) begin
                    col <= '0;
                    if (line < V_L) begin
                        line <= line + 1'b1;
                        base <= base + line_step;
                    end
                end
            end
        end

    // output register; strobes are squashed as soon as capture is disarmed
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pix_data    <= '0;
            pix_addr    <= '0;
        end else begin
            pix_valid   <= c_v & config_done;
            frame_start <= c_fs & config_done;
            frame_done  <= c_fd & config_done;
            if (c_v && config_done) begin
                pix_data <= c_data;
                pix_addr <= c_addr;
            end
        end
endmodule
